// File: rtl/collision_scanner.sv
// Scans a per-target hitbox against the bullet-grid RAM, one cell per clock,
// and keeps per-target health, invulnerability timers and dead flags.
module collision_scanner #(
  parameter int NUM_TGT    = 2,
  parameter int GRID_W     = 160,
  parameter int GRID_H     = 120,
  parameter int ADDR_W     = 15,
  parameter int HB_W       = 2,
  parameter int HB_H       = 2,
  parameter int MAX_HP     = 5,
  parameter int HP_W       = 3,
  parameter int INV_CYCLES = 50,
  parameter int INV_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_game_en,
  input  logic                    scan_start,
  input  logic [NUM_TGT*8-1:0]    tgt_x,
  input  logic [NUM_TGT*7-1:0]    tgt_y,
  output logic                    grid_rd_en,
  output logic [ADDR_W-1:0]       grid_rd_addr,
  input  logic                    grid_rd_data,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_TGT-1:0]      hit,
  output logic [NUM_TGT*HP_W-1:0] health,
  output logic [NUM_TGT-1:0]      dead,
  output logic [NUM_TGT-1:0]      invuln,
  output logic [1:0]              state_dbg
);

  localparam int TGT_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, UPDATE} state_t;

  state_t                 state;
  logic [NUM_TGT*8-1:0]   lat_x;
  logic [NUM_TGT*7-1:0]   lat_y;
  logic [TGT_W-1:0]       tgt_idx;
  logic [2:0]             dx;
  logic [2:0]             dy;
  logic [NUM_TGT-1:0]     hit_acc;
  logic                   rd_vld_q;
  logic [TGT_W-1:0]       rd_tgt_q;
  logic [HP_W-1:0]        hp  [NUM_TGT];
  logic [INV_W-1:0]       inv [NUM_TGT];

  logic [7:0]             cur_x;
  logic [6:0]             cur_y;
  logic [8:0]             cx;
  logic [8:0]             cy;
  logic                   in_grid;
  logic [ADDR_W-1:0]      cell_addr;

  // 9-bit sums so a hitbox hanging off the right/bottom edge is clipped, never wrapped.
  always_comb begin
    cur_x     = lat_x[tgt_idx*8 +: 8];
    cur_y     = lat_y[tgt_idx*7 +: 7];
    cx        = {1'b0, cur_x} + {6'b0, dx};
    cy        = {2'b0, cur_y} + {6'b0, dy};
    in_grid   = (32'(cx) < GRID_W) && (32'(cy) < GRID_H);
    cell_addr = ADDR_W'(GRID_H) * ADDR_W'(cx) + ADDR_W'(cy);
    grid_rd_en   = (state == SCAN) && in_grid;
    grid_rd_addr = grid_rd_en ? cell_addr : '0;
  end

  always_comb begin
    health = '0;
    dead   = '0;
    invuln = '0;
    for (int t = 0; t < NUM_TGT; t++) begin
      health[t*HP_W +: HP_W] = hp[t];
      dead[t]                = (hp[t] == '0);
      invuln[t]              = (inv[t] != '0);
    end
  end

  assign busy      = (state != IDLE) || done;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lat_x    <= '0;
      lat_y    <= '0;
      tgt_idx  <= '0;
      dx       <= '0;
      dy       <= '0;
      hit_acc  <= '0;
      rd_vld_q <= 1'b0;
      rd_tgt_q <= '0;
      done     <= 1'b0;
      hit      <= '0;
      for (int t = 0; t < NUM_TGT; t++) begin
        hp[t]  <= HP_W'(MAX_HP);
        inv[t] <= '0;
      end
    end else if (start_game_en) begin
      state    <= IDLE;
      tgt_idx  <= '0;
      dx       <= '0;
      dy       <= '0;
      hit_acc  <= '0;
      rd_vld_q <= 1'b0;
      done     <= 1'b0;
      hit      <= '0;
      for (int t = 0; t < NUM_TGT; t++) begin
        hp[t]  <= HP_W'(MAX_HP);
        inv[t] <= '0;
      end
    end else begin
      done <= 1'b0;
      hit  <= '0;
      for (int t = 0; t < NUM_TGT; t++)
        if (inv[t] != '0) inv[t] <= inv[t] - 1'b1;
      // Read data arrives one clock after the strobe; the target tag travels with it.
      if (rd_vld_q && grid_rd_data) hit_acc[rd_tgt_q] <= 1'b1;
      rd_vld_q <= grid_rd_en;
      rd_tgt_q <= tgt_idx;
      case (state)
        IDLE: begin
          if (scan_start) begin
            lat_x   <= tgt_x;
            lat_y   <= tgt_y;
            tgt_idx <= '0;
            dx      <= '0;
            dy      <= '0;
            hit_acc <= '0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (dy == 3'(HB_H - 1)) begin
            dy <= '0;
            if (dx == 3'(HB_W - 1)) begin
              dx <= '0;
              if (tgt_idx == TGT_W'(NUM_TGT - 1)) state <= DRAIN;
              else tgt_idx <= tgt_idx + TGT_W'(1);
            end else begin
              dx <= dx + 3'd1;
            end
          end else begin
            dy <= dy + 3'd1;
          end
        end
        DRAIN: state <= UPDATE;
        UPDATE: begin
          done  <= 1'b1;
          state <= IDLE;
          // A load here overrides the decrement above; invulnerable or dead targets absorb the hit.
          for (int t = 0; t < NUM_TGT; t++) begin
            if (hit_acc[t] && (inv[t] == '0) && (hp[t] != '0)) begin
              hit[t] <= 1'b1;
              hp[t]  <= hp[t] - 1'b1;
              inv[t] <= INV_W'(INV_CYCLES);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner with a behavioural 1-cycle-latency grid RAM.
module tb_collision_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_game_en = 1'b0;
  logic        scan_start = 1'b0;
  logic [15:0] tgt_x = '0;
  logic [13:0] tgt_y = '0;
  logic        grid_rd_en;
  logic [14:0] grid_rd_addr;
  logic        grid_rd_data = 1'b0;
  logic        busy;
  logic        done;
  logic [1:0]  hit;
  logic [5:0]  health;
  logic [1:0]  dead;
  logic [1:0]  invuln;
  logic [1:0]  state_dbg;

  logic        grid_mem [0:19199];
  int          rd_cnt = 0;
  int          rd_corner = 0;
  int          rd_oor = 0;
  int          tests = 0;
  int          fails = 0;

  collision_scanner dut (
    .clk(clk), .rst(rst), .start_game_en(start_game_en), .scan_start(scan_start),
    .tgt_x(tgt_x), .tgt_y(tgt_y), .grid_rd_en(grid_rd_en), .grid_rd_addr(grid_rd_addr),
    .grid_rd_data(grid_rd_data), .busy(busy), .done(done), .hit(hit), .health(health),
    .dead(dead), .invuln(invuln), .state_dbg(state_dbg)
  );

  always #10 clk = ~clk;

  // Grid RAM model: registered read, plus address bookkeeping.
  always @(posedge clk) begin
    grid_rd_data <= grid_rd_en ? ((grid_rd_addr <= 15'd19199) ? grid_mem[grid_rd_addr] : 1'b0) : 1'b0;
    if (grid_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (grid_rd_addr == 15'd19199) rd_corner <= rd_corner + 1;
      if (grid_rd_addr > 15'd19199)  rd_oor <= rd_oor + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_grid(input logic v);
    for (int a = 0; a < 19200; a++) grid_mem[a] = v;
  endtask

  // scan_start in cycle 0; returns the cycle number in which done was seen (0 = timeout).
  task automatic run_scan(output int lat, output logic busy1);
    int c;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    busy1 = busy;
    c = 1;
    while (!done && c < 50) begin
      tick();
      c++;
    end
    lat = done ? c : 0;
  endtask

  task automatic wait_invuln_clear(input string tag);
    int c;
    c = 0;
    while (invuln[0] && c < 200) begin
      tick();
      c++;
    end
    check(tag, 32'(invuln[0]), 32'd0);
  endtask

  task automatic pulse_restart();
    start_game_en = 1'b1;
    tick();
    start_game_en = 1'b0;
  endtask

  initial begin
    int   lat;
    logic b1;
    int   r0, rc0, ro0;
    int   ndone;

    fill_grid(1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    check("reset_busy",   32'(busy),       32'd0);
    check("reset_done",   32'(done),       32'd0);
    check("reset_health", 32'(health),     32'h2D);
    check("reset_dead",   32'(dead),       32'd0);
    check("reset_invuln", 32'(invuln),     32'd0);
    check("reset_rd_en",  32'(grid_rd_en), 32'd0);

    // Single hit on the player: cell (11,21) -> addr 1341
    grid_mem[1341] = 1'b1;
    tgt_x = {8'd100, 8'd10};
    tgt_y = {7'd100, 7'd20};
    run_scan(lat, b1);
    check("hit1_busy_c1", 32'(b1),     32'd1);
    check("hit1_latency", 32'(lat),    32'd11);
    check("hit1_hit",     32'(hit),    32'h1);
    check("hit1_health",  32'(health), 32'h2C);
    check("hit1_invuln",  32'(invuln), 32'h1);
    check("hit1_busy_d",  32'(busy),   32'd1);

    // Back-to-back rescan in the done cycle: absorbed by invulnerability
    run_scan(lat, b1);
    check("inv_latency", 32'(lat),    32'd11);
    check("inv_hit",     32'(hit),    32'h0);
    check("inv_health",  32'(health), 32'h2C);
    tick();
    check("inv_done_pulse", 32'(done), 32'd0);
    check("inv_busy_after", 32'(busy), 32'd0);

    wait_invuln_clear("inv_expire");
    run_scan(lat, b1);
    check("hit2_hit",    32'(hit),    32'h1);
    check("hit2_health", 32'(health), 32'h2B);

    // Edge clipping: target1 at the bottom-right corner, whole grid set
    fill_grid(1'b1);
    tgt_x = {8'd159, 8'd10};
    tgt_y = {7'd119, 7'd20};
    r0 = rd_cnt; rc0 = rd_corner; ro0 = rd_oor;
    run_scan(lat, b1);
    check("clip_latency", 32'(lat),             32'd11);
    check("clip_reads",   32'(rd_cnt - r0),     32'd5);
    check("clip_corner",  32'(rd_corner - rc0), 32'd1);
    check("clip_oor",     32'(rd_oor - ro0),    32'd0);
    check("clip_hit",     32'(hit),             32'h2);
    check("clip_health",  32'(health),          32'h23);

    // Restart, then five spaced hits to kill the player
    fill_grid(1'b0);
    grid_mem[1341] = 1'b1;
    tgt_x = {8'd100, 8'd10};
    tgt_y = {7'd100, 7'd20};
    pulse_restart();
    check("restart_health", 32'(health), 32'h2D);
    check("restart_invuln", 32'(invuln), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      wait_invuln_clear("death_wait");
      run_scan(lat, b1);
      check("death_hit",    32'(hit),    32'h1);
      check("death_health", 32'(health), 32'(6'h28 | (5 - k)));
    end
    check("death_dead", 32'(dead), 32'h1);
    wait_invuln_clear("sat_wait");
    run_scan(lat, b1);
    check("sat_hit",    32'(hit),    32'h0);
    check("sat_health", 32'(health), 32'h28);
    check("sat_dead",   32'(dead),   32'h1);

    // start_game_en mid-scan discards the pass
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    tick();
    tick();
    pulse_restart();
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_health", 32'(health), 32'h2D);
    check("abort_dead",   32'(dead),   32'd0);
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      if (done) ndone++;
      tick();
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run_scan(lat, b1);
    check("abort_next_latency", 32'(lat),    32'd11);
    check("abort_next_hit",     32'(hit),    32'h1);
    check("abort_next_health",  32'(health), 32'h2C);

    // scan_start held while busy is ignored
    wait_invuln_clear("busy_wait");
    ndone = 0;
    scan_start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 6) scan_start = 1'b0;
      if (done) ndone++;
      if (c == 11) check("busy_ign_done_c11", 32'(done), 32'd1);
    end
    check("busy_ign_count",  32'(ndone),  32'd1);
    check("busy_ign_health", 32'(health), 32'h2B);

    // Asynchronous reset mid-scan
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    tick();
    tick();
    #3;
    rst = 1'b0;
    #1;
    check("arst_busy",   32'(busy),       32'd0);
    check("arst_health", 32'(health),     32'h2D);
    check("arst_dead",   32'(dead),       32'd0);
    check("arst_rd_en",  32'(grid_rd_en), 32'd0);
    check("arst_invuln", 32'(invuln),     32'd0);
    tick();
    rst = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
